// File: rtl/dcache_refill_ctrl.sv
// Data-cache read sequencer: tag lookup, 8-beat burst refill on miss, and flush via
// the storage's synchronous valid-bit clear.
`timescale 1ns/1ps

module dcache_refill_ctrl #(
    parameter  int unsigned DW_OFFSET_WIDTH = 3,
    parameter  int unsigned LINE_WIDTH      = 6,
    localparam int unsigned TAG_WIDTH       = 32 - DW_OFFSET_WIDTH - 3 - LINE_WIDTH,
    localparam int unsigned BLOCK_DW        = 1 << DW_OFFSET_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    // core request / response
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [63:0]               resp_data,
    input  logic                      flush_req,
    output logic                      flush_done,
    // storage arrays
    output logic [31:0]               cache_addr,
    input  logic [63:0]               cache_data,
    input  logic [TAG_WIDTH-1:0]      cache_tag,
    input  logic                      cache_tag_valid,
    output logic [LINE_WIDTH-1:0]     cache_wr_line,
    output logic [64*BLOCK_DW-1:0]    cache_wr_block,
    output logic [TAG_WIDTH-1:0]      cache_wr_tag,
    output logic [BLOCK_DW-1:0]       cache_wr_mask,
    output logic                      cache_wr_en,
    output logic                      cache_clear,
    // memory burst read
    output logic                      mem_ar_valid,
    input  logic                      mem_ar_ready,
    output logic [31:0]               mem_ar_addr,
    input  logic                      mem_r_valid,
    output logic                      mem_r_ready,
    input  logic [63:0]               mem_r_data,
    input  logic                      mem_r_last,
    output logic                      protocol_error
);

    localparam int unsigned OFF_LSB = DW_OFFSET_WIDTH + 3;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LOOKUP,
        S_AR,
        S_FILL,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                            state_q;
    state_t                            state_d;
    logic [31:3]                       addr_q;
    logic [31:0]                       cache_addr_q;
    logic [BLOCK_DW-1:0][63:0]         fill_buf;
    logic [DW_OFFSET_WIDTH-1:0]        beat_q;
    logic                              flush_q;
    logic                              hit;
    logic                              accept;
    logic                              beat_last;

    assign hit       = cache_tag_valid && (cache_tag == addr_q[31 -: TAG_WIDTH]);
    assign accept    = (state_q == S_IDLE) && !flush_req && req_valid;
    assign beat_last = (beat_q == DW_OFFSET_WIDTH'(BLOCK_DW - 1));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR:  state_d = S_IDLE;
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_CLEAR;
                end else if (req_valid) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = hit ? S_RESP : S_AR;
            S_AR:     if (mem_ar_ready) state_d = S_FILL;
            S_FILL:   if (mem_r_valid && beat_last) state_d = S_WRITE;
            S_WRITE:  state_d = S_RESP;
            S_RESP:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_CLEAR;
        endcase
    end

    // Request latch, fill assembly, response capture and error tracking
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q         <= '0;
            cache_addr_q   <= '0;
            fill_buf       <= '0;
            beat_q         <= '0;
            resp_data      <= '0;
            flush_q        <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                cache_addr_q <= req_addr;
            end
            if (accept) begin
                addr_q <= req_addr[31:3];
            end
            // Only a flush-initiated CLEAR reports completion; the post-reset one does not.
            if (state_q == S_IDLE && flush_req) begin
                flush_q <= 1'b1;
            end else if (state_q == S_CLEAR) begin
                flush_q <= 1'b0;
            end
            if (state_q == S_LOOKUP && hit) begin
                resp_data <= cache_data;
            end
            if (state_q == S_AR) begin
                beat_q <= '0;
            end
            if (state_q == S_FILL && mem_r_valid) begin
                fill_buf[beat_q] <= mem_r_data;
                beat_q           <= beat_q + DW_OFFSET_WIDTH'(1);
                if (beat_q == addr_q[3 +: DW_OFFSET_WIDTH]) begin
                    resp_data <= mem_r_data;
                end
                if (mem_r_last != beat_last) begin
                    protocol_error <= 1'b1;
                end
            end
        end
    end

    // Handshake and strobe outputs decode directly from the state register
    assign req_ready      = (state_q == S_IDLE) && !flush_req;
    assign resp_valid     = (state_q == S_RESP);
    assign mem_ar_valid   = (state_q == S_AR);
    assign mem_r_ready    = (state_q == S_FILL);
    assign cache_clear    = (state_q == S_CLEAR);
    assign flush_done     = (state_q == S_CLEAR) && flush_q;
    assign cache_wr_en    = (state_q == S_WRITE);
    assign cache_wr_mask  = (state_q == S_WRITE) ? '1 : '0;

    assign cache_wr_line  = addr_q[OFF_LSB +: LINE_WIDTH];
    assign cache_wr_tag   = addr_q[31 -: TAG_WIDTH];
    assign cache_wr_block = fill_buf;
    assign mem_ar_addr    = {addr_q[31:OFF_LSB], OFF_LSB'(0)};

    // Lookup address goes straight through in IDLE so the storage read lands in LOOKUP
    assign cache_addr     = (state_q == S_IDLE) ? req_addr : cache_addr_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Bench for dcache_refill_ctrl: behavioural storage arrays and memory responder,
// expected load data queued at request time and compared at the response handshake.
`timescale 1ns/1ps

module tb_dcache_refill_ctrl;

    localparam int unsigned TW = 20;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            req_valid, req_ready;
    logic [31:0]     req_addr;
    logic            resp_valid, resp_ready;
    logic [63:0]     resp_data;
    logic            flush_req, flush_done;
    logic [31:0]     cache_addr;
    logic [63:0]     cache_data;
    logic [TW-1:0]   cache_tag;
    logic            cache_tag_valid;
    logic [5:0]      cache_wr_line;
    logic [511:0]    cache_wr_block;
    logic [TW-1:0]   cache_wr_tag;
    logic [7:0]      cache_wr_mask;
    logic            cache_wr_en, cache_clear;
    logic            mem_ar_valid, mem_ar_ready;
    logic [31:0]     mem_ar_addr;
    logic            mem_r_valid, mem_r_ready;
    logic [63:0]     mem_r_data;
    logic            mem_r_last;
    logic            protocol_error;

    dcache_refill_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .flush_req(flush_req), .flush_done(flush_done),
        .cache_addr(cache_addr), .cache_data(cache_data), .cache_tag(cache_tag),
        .cache_tag_valid(cache_tag_valid), .cache_wr_line(cache_wr_line),
        .cache_wr_block(cache_wr_block), .cache_wr_tag(cache_wr_tag),
        .cache_wr_mask(cache_wr_mask), .cache_wr_en(cache_wr_en), .cache_clear(cache_clear),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data),
        .mem_r_last(mem_r_last), .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // Storage arrays: 1-cycle read; they start full of stale valid lines tagged 0x00001,
    // which only the controller's CLEAR cycle can wipe.
    logic [511:0]  st_blk [64];
    logic [TW-1:0] st_tag [64];
    logic [63:0]   st_valid;
    bit            st_init = 1'b1;

    always @(posedge clock) begin
        cache_data      <= st_blk[cache_addr[11:6]][int'(cache_addr[5:3]) * 64 +: 64];
        cache_tag       <= st_tag[cache_addr[11:6]];
        cache_tag_valid <= st_valid[cache_addr[11:6]];
        if (st_init) begin
            for (int i = 0; i < 64; i++) begin
                st_blk[i] <= '0;
                st_tag[i] <= TW'(1);
            end
            st_valid <= '1;
            st_init  <= 1'b0;
        end else begin
            if (cache_clear && reset_n) st_valid <= '0;
            if (cache_wr_en) begin
                st_blk[cache_wr_line]   <= cache_wr_block;
                st_tag[cache_wr_line]   <= cache_wr_tag;
                st_valid[cache_wr_line] <= 1'b1;
            end
        end
    end

    int unsigned  n_pass   = 0;
    int unsigned  n_checks = 0;
    logic [63:0]  sb_q[$];
    logic [63:0]  ref_dw [64][8];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One load from request to response handshake, with the memory side answered inline
    task automatic do_load(input logic [31:0] addr, input bit exp_miss, input logic [63:0] base,
                           input int last_beat, input int hold, input bit exp_perr);
        int           line, word, c0, beat, writes, held, ar_delay;
        bit           acc, ar_any, saw_ar, done, seen_resp;
        logic [63:0]  first_data;
        logic [511:0] exp_blk;
        line = int'(addr[11:6]);
        word = int'(addr[5:3]);
        for (int j = 0; j < 8; j++) begin
            exp_blk[64*j +: 64] = base + 64'(j);
            if (exp_miss) ref_dw[line][j] = base + 64'(j);
        end
        sb_q.push_back(ref_dw[line][word]);
        c0 = 0; beat = 0; writes = 0; held = 0; ar_delay = $urandom_range(0, 2);
        acc = 0; ar_any = 0; saw_ar = 0; done = 0; seen_resp = 0; first_data = '0;

        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            if (req_ready) begin
                acc = 1;
                c0  = int'(cyc);
            end else begin
                @(negedge clock);
            end
        end
        if (!acc) check("req_accept", 0, 1);

        for (int i = 0; i < 300 && acc && !done; i++) begin
            @(negedge clock);
            req_valid    = 1'b0;
            req_addr     = $urandom;
            mem_ar_ready = 1'b0;
            mem_r_valid  = 1'b0;
            mem_r_data   = {$urandom, $urandom};
            mem_r_last   = 1'($urandom_range(0, 1));
            resp_ready   = 1'b0;
            if (mem_ar_valid) ar_any = 1;
            if (mem_ar_valid && !saw_ar) begin
                if (ar_delay > 0) begin
                    ar_delay--;
                end else begin
                    check("ar_addr", mem_ar_addr, {addr[31:6], 6'b0});
                    saw_ar       = 1;
                    mem_ar_ready = 1'b1;
                end
            end
            if (mem_r_ready && beat < 8 && $urandom_range(0, 3) != 0) begin
                mem_r_valid = 1'b1;
                mem_r_data  = base + 64'(beat);
                mem_r_last  = (beat == last_beat);
                beat++;
            end
            if (cache_wr_en) begin
                writes++;
                check("wr_line",  cache_wr_line, addr[11:6]);
                check("wr_tag",   cache_wr_tag, addr[31:12]);
                check("wr_mask",  cache_wr_mask, 8'hFF);
                check("wr_block", cache_wr_block, exp_blk);
            end
            if (resp_valid) begin
                if (!seen_resp) begin
                    seen_resp  = 1;
                    first_data = resp_data;
                    if (!exp_miss) check("hit_latency", int'(cyc) - c0, 2);
                end
                if (held >= hold) begin
                    resp_ready = 1'b1;
                    check("resp_stable", resp_data, first_data);
                    if (sb_q.size() == 0) check("sb_empty", 1, 0);
                    else check("resp_data", resp_data, sb_q.pop_front());
                    done = 1;
                end else begin
                    held++;
                end
            end
        end
        if (acc && !done) check("resp_timeout", 0, 1);
        @(negedge clock);
        resp_ready  = 1'b0;
        mem_r_valid = 1'b0;
        #1;
        check("resp_drop", resp_valid, 0);
        check("miss",      ar_any, exp_miss);
        check("wr_count",  writes, exp_miss ? 1 : 0);
        check("perr",      protocol_error, exp_perr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; flush_req = 1'b0;
        mem_ar_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = '0; mem_r_last = 1'b0;
        for (int l = 0; l < 64; l++) for (int w = 0; w < 8; w++) ref_dw[l][w] = '0;

        repeat (3) @(negedge clock);
        check("rst_clear",   cache_clear, 1);
        check("rst_fdone",   flush_done, 0);
        check("rst_rready",  req_ready, 0);
        check("rst_outs",    {resp_valid, mem_ar_valid, mem_r_ready, cache_wr_en, protocol_error}, 0);
        check("rst_data",    {resp_data, cache_addr, mem_ar_addr, cache_wr_mask}, 0);
        reset_n = 1'b1;
        #1;
        check("rel_clear",   cache_clear, 1);
        check("rel_rready",  req_ready, 0);
        @(negedge clock);
        #1;
        check("idle_clear",  cache_clear, 0);
        check("idle_fdone",  flush_done, 0);
        check("idle_rready", req_ready, 1);

        do_load(32'h0000_1040, 1, 64'h200, 7, 0, 0);
        do_load(32'h0000_2058, 1, 64'h100, 7, 0, 0);
        do_load(32'h0000_2048, 0, 64'h0,   7, 0, 0);
        do_load(32'h0000_3048, 1, 64'h300, 7, 1, 0);
        do_load(32'h0000_2048, 1, 64'h100, 7, 0, 0);
        do_load(32'h0000_3048, 1, 64'h300, 7, 0, 0);
        do_load(32'h0000_3048, 0, 64'h0,   7, 2, 0);
        do_load(32'hABCD_E7F8, 1, 64'h7000, 7, 0, 0);

        // Flush with a competing request: flush wins and the request waits
        @(negedge clock);
        flush_req = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_3048;
        #1;
        check("fl_rready",   req_ready, 0);
        @(negedge clock);
        flush_req = 1'b0;
        req_valid = 1'b0;
        #1;
        check("fl_clear",    cache_clear, 1);
        check("fl_done",     flush_done, 1);
        check("fl_rready2",  req_ready, 0);
        @(negedge clock);
        #1;
        check("fl_clear_off", cache_clear, 0);
        check("fl_done_off",  flush_done, 0);

        do_load(32'h0000_3048, 1, 64'h600, 5, 4, 1);
        do_load(32'h0000_3058, 0, 64'h0,   7, 0, 1);
        do_load(32'hABCD_E7F8, 1, 64'h800, 7, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
